// File: rtl/jericalla_pkg.sv
// Shared constants for the JERICALLA sequencer: opcodes, ALU codes, FSM states, instruction fields.
// Optional single-step mode is enabled with the SEQ_STEP_EN macro in the top module.
package jericalla_pkg;

    localparam logic [1:0] OP_ARITH = 2'b00;
    localparam logic [1:0] OP_LOGIC = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_MEM    = 3'd5;
    localparam state_t ST_HALT   = 3'd6;

    localparam int INSTR_W = 17;
    localparam int OP_HI   = 16;
    localparam int OP_LO   = 15;
    localparam int RD_HI   = 14;
    localparam int RD_LO   = 10;
    localparam int RS1_HI  = 9;
    localparam int RS1_LO  = 5;
    localparam int RS2_HI  = 4;
    localparam int RS2_LO  = 0;

endpackage

// File: rtl/jericalla_alu_decode.sv
// Combinational opcode/function to alu_sel translation in the legacy alu_sel encoding.
module jericalla_alu_decode
    import jericalla_pkg::*;
(
    input  logic [1:0] opcode,
    input  logic [4:0] func,
    output logic [2:0] alu_sel
);

    always_comb begin
        alu_sel = ALU_AND;
        if (opcode == OP_ARITH) begin
            case (func)
                5'd0:    alu_sel = ALU_ADD;
                5'd1:    alu_sel = ALU_SUB;
                5'd2:    alu_sel = ALU_SLT;
                default: alu_sel = ALU_AND;
            endcase
        end else if (opcode == OP_LOGIC) begin
            case (func)
                5'd0:    alu_sel = ALU_AND;
                5'd1:    alu_sel = ALU_OR;
                5'd2:    alu_sel = ALU_NOR;
                default: alu_sel = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/jericalla_sequencer.sv
// Multi-cycle fetch/decode/exec/write sequencer owning the PC and datapath strobes.
// Defining SEQ_STEP_EN adds a step input that gates each fetch to one instruction per pulse.
module jericalla_sequencer
    import jericalla_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int START_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [2:0]         alu_sel,
    output logic               we_reg,
    output logic               we_mem,
    output logic               sel_mem,
    output logic               busy,
    output logic               halted,
    output logic [2:0]         state_dbg
);

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

    state_t               state;
    logic [PC_W-1:0]      pc;
    logic [INSTR_W-1:0]   ir;
    logic [2:0]           dec_alu_sel;
    logic                 fetch_go;
    logic                 fetch_done;
    logic [1:0]           ir_op;

    assign ir_op = ir[OP_HI:OP_LO];

    jericalla_alu_decode u_alu_decode (
        .opcode  (ir_op),
        .func    (ir[RS1_HI:RS1_LO]),
        .alu_sel (dec_alu_sel)
    );

`ifdef SEQ_STEP_EN
    // A step seen at any time arms one fetch; the flag drops when that instruction retires.
    logic step_pending;
    logic retire;
    assign retire   = (state == ST_WB) || (state == ST_MEM) ||
                      ((state == ST_DECODE) && (ir_op == OP_HALT));
    assign fetch_go = step_pending;

    always_ff @(posedge clk) begin
        if (rst)         step_pending <= 1'b0;
        else if (retire) step_pending <= step;
        else if (step)   step_pending <= 1'b1;
    end
`else
    assign fetch_go = 1'b1;
`endif

    // Handshake: a fetch completes on any cycle where imem_req and imem_ack are both high.
    assign fetch_done = imem_req && imem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= START_ADDR;
            ir    <= '0;
            rd    <= '0;
            rs1   <= '0;
            rs2   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_FETCH;
                ST_FETCH: begin
                    if (fetch_done) begin
                        ir    <= imem_rdata;
                        pc    <= pc + 1'b1;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rd    <= ir[RD_HI:RD_LO];
                    rs1   <= ir[RS1_HI:RS1_LO];
                    rs2   <= ir[RS2_HI:RS2_LO];
                    state <= (ir_op == OP_HALT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: state <= (ir_op == OP_STORE) ? ST_MEM : ST_WB;
                ST_WB:   state <= ST_FETCH;
                ST_MEM:  state <= ST_FETCH;
                ST_HALT: begin
                    if (start) begin
                        pc    <= START_ADDR;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == ST_FETCH) && fetch_go;
    assign imem_addr = pc;
    assign alu_sel   = ((state == ST_EXEC) || (state == ST_WB)) ? dec_alu_sel : ALU_AND;
    assign we_reg    = (state == ST_WB);
    assign we_mem    = (state == ST_MEM);
    assign sel_mem   = (state == ST_MEM);
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed bench for jericalla_sequencer: inputs driven and outputs checked on the falling edge.
module tb_jericalla_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [16:0] imem_rdata;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  alu_sel;
    logic        we_reg, we_mem, sel_mem, busy, halted;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    jericalla_sequencer #(.PC_W(8), .START_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .alu_sel    (alu_sel),
        .we_reg     (we_reg),
        .we_mem     (we_mem),
        .sel_mem    (sel_mem),
        .busy       (busy),
        .halted     (halted),
        .state_dbg  (state_dbg)
    );

    function automatic logic [16:0] mk(input logic [1:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] addr);
        check({tag, "_req"},    {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"},   {24'd0, imem_addr}, {24'd0, addr});
        check({tag, "_regs"},   {17'd0, rd, rs1, rs2}, 32'd0);
        check({tag, "_alu"},    {29'd0, alu_sel}, 32'd0);
        check({tag, "_strobe"}, {28'd0, we_reg, we_mem, sel_mem, busy}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    // Runs one ALU instruction from a FETCH cycle with immediate ack; alu_sel comes from exp_q.
    task automatic drive_alu_instr(input logic [16:0] instr);
        logic [2:0] exp_alu;
        exp_alu    = exp_q.pop_front();
        imem_ack   = 1'b1;
        imem_rdata = instr;
        tick();
        imem_ack = 1'b0;
        tick();
        check("exec_alu_sel", {29'd0, alu_sel}, {29'd0, exp_alu});
        tick();
        check("wb_alu_sel", {29'd0, alu_sel}, {29'd0, exp_alu});
        check("wb_we_reg", {31'd0, we_reg}, 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        check_idle_outputs("reset", 8'd0);
        rst = 1'b0; start = 1'b1;
        tick();
        // ADD r3, rs1=0, rs2=4 with immediate ack
        check("f1_req", {31'd0, imem_req}, 32'd1);
        check("f1_addr", {24'd0, imem_addr}, 32'd0);
        check("f1_busy", {31'd0, busy}, 32'd1);
        start = 1'b0; imem_ack = 1'b1; imem_rdata = mk(2'b00, 5'd3, 5'd0, 5'd4);
        tick();
        imem_ack = 1'b0;
        check("dec_req", {31'd0, imem_req}, 32'd0);
        check("dec_alu", {29'd0, alu_sel}, 32'd0);
        tick();
        check("ex_rd", {27'd0, rd}, 32'd3);
        check("ex_rs2", {27'd0, rs2}, 32'd4);
        check("ex_alu", {29'd0, alu_sel}, 32'd2);
        check("ex_we_reg", {31'd0, we_reg}, 32'd0);
        tick();
        check("wb_we_reg_add", {31'd0, we_reg}, 32'd1);
        check("wb_alu_add", {29'd0, alu_sel}, 32'd2);
        tick();
        check("f2_req", {31'd0, imem_req}, 32'd1);
        check("f2_addr", {24'd0, imem_addr}, 32'd1);
        check("f2_we_reg", {31'd0, we_reg}, 32'd0);
        check("f2_alu", {29'd0, alu_sel}, 32'd0);

        // store with ack delayed 3 cycles: req held 4 cycles
        for (int i = 0; i < 3; i++) begin
            check("st_wait_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        check("st_req4", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = mk(2'b10, 5'd1, 5'd2, 5'd5);
        tick();
        imem_ack = 1'b0;
        tick();
        check("st_ex_alu", {29'd0, alu_sel}, 32'd0);
        check("st_ex_we_mem", {31'd0, we_mem}, 32'd0);
        tick();
        check("st_mem_strobes", {29'd0, we_mem, sel_mem, we_reg}, 32'b110);
        check("st_mem_alu", {29'd0, alu_sel}, 32'd0);
        tick();
        check("st_after_we_mem", {30'd0, we_mem, sel_mem}, 32'd0);
        check("st_next_addr", {24'd0, imem_addr}, 32'd2);

        // OR, NOR, logic func=7
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b000);
        drive_alu_instr(mk(2'b01, 5'd7, 5'd1, 5'd8));
        drive_alu_instr(mk(2'b01, 5'd9, 5'd2, 5'd10));
        drive_alu_instr(mk(2'b01, 5'd11, 5'd7, 5'd12));
        check("seq_addr", {24'd0, imem_addr}, 32'd5);

        // HALT at pc=5
        imem_ack = 1'b1; imem_rdata = mk(2'b11, 5'd0, 5'd0, 5'd0);
        tick();
        imem_ack = 1'b0;
        tick(); tick();
        check("halt_flags", {30'd0, halted, busy}, 32'b10);
        check("halt_addr", {24'd0, imem_addr}, 32'd6);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("halt_hold_addr", {24'd0, imem_addr}, 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_addr", {24'd0, imem_addr}, 32'd0);
        check("restart_req", {31'd0, imem_req}, 32'd1);
        check("restart_halted", {31'd0, halted}, 32'd0);

        // run 255 ADDs to reach pc=255, then one more to wrap
        for (int i = 0; i < 255; i++) begin
            imem_ack = 1'b1; imem_rdata = mk(2'b00, 5'd1, 5'd0, 5'd2);
            tick();
            imem_ack = 1'b0;
            tick(); tick(); tick();
        end
        check("wrap_pre_addr", {24'd0, imem_addr}, 32'd255);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick(); tick(); tick();
        check("wrap_addr", {24'd0, imem_addr}, 32'd0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_addr", {24'd0, imem_addr}, 32'd1);

        // reset during a FETCH wait
        tick();
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("mid_fetch_rst", 8'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_idle_req", {31'd0, imem_req}, 32'd0);

`ifdef SEQ_STEP_EN
        step = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("step_no_req", {31'd0, imem_req}, 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_req", {31'd0, imem_req}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
